// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S receiver and transmitter.
package i2s_pkg;

    // Receiver synchronisation state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } i2s_state_e;

    // Width of the per-word bit counter; it saturates at all-ones (63).
    localparam int BITCNT_W = 6;

    // LRCK channel encoding.
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: brings the three asynchronous I2S pins into clk_sys and
// flags the BCK rising edge. rise/lr/d are registered together so that the
// LRCK and DATA samples always belong to the BCK edge they are reported with.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i2s_bck,
    input  logic i2s_lrck,
    input  logic i2s_data,
    output logic rise,
    output logic lr,
    output logic d
);

    logic [SYNC_STAGES-1:0] bck_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic                   bck_prev;

    // Synchroniser chains, previous-BCK register and the registered edge/sample outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bck_sync <= '0;
            lr_sync  <= '0;
            d_sync   <= '0;
            bck_prev <= 1'b0;
            rise     <= 1'b0;
            lr       <= 1'b0;
            d        <= 1'b0;
        end else begin
            bck_sync <= {bck_sync[SYNC_STAGES-2:0], i2s_bck};
            lr_sync  <= {lr_sync[SYNC_STAGES-2:0], i2s_lrck};
            d_sync   <= {d_sync[SYNC_STAGES-2:0], i2s_data};
            bck_prev <= bck_sync[SYNC_STAGES-1];
            rise     <= bck_sync[SYNC_STAGES-1] & ~bck_prev;
            lr       <= lr_sync[SYNC_STAGES-1];
            d        <= d_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver. Shifts serial data in on each BCK
// rising edge, commits a word whenever LRCK changes (that bit being the LSB
// of the outgoing word), and presents left/right pairs with a strobe once the
// stream has been seen to carry a complete left-then-right frame.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_BITS    = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                i2s_bck,
    input  logic                i2s_lrck,
    input  logic                i2s_data,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                sample_strobe,
    output logic                locked,
    output logic                frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // Bit counter increment that sticks at its maximum on very long words.
    function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
        return (v == {BITCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Short words are left-justified so their MSB lands on the sample MSB.
    function automatic logic [AUDIO_DW-1:0] justify(input logic [AUDIO_DW-1:0] w,
                                                    input logic [BITCNT_W-1:0] n);
        if (int'(n) < AUDIO_DW)
            return w << (AUDIO_DW - int'(n));
        else
            return w;
    endfunction

    logic                rise;
    logic                lr;
    logic                d;

    i2s_state_e          state;
    logic [AUDIO_DW-1:0] shreg;
    logic [BITCNT_W-1:0] bitcnt;
    logic                lr_prev;
    logic [AUDIO_DW-1:0] hold_left;
    logic                have_left;
    logic [TMO_W-1:0]    tmo_cnt;

    logic [AUDIO_DW-1:0] word_next;
    logic [BITCNT_W-1:0] nbits;
    logic [AUDIO_DW-1:0] word_out;
    logic                boundary;
    logic                short_word;
    logic                tmo_hit;

    i2s_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .i2s_bck  (i2s_bck),
        .i2s_lrck (i2s_lrck),
        .i2s_data (i2s_data),
        .rise     (rise),
        .lr       (lr),
        .d        (d)
    );

    // Word including the current bit; bits past AUDIO_DW are dropped (truncation).
    assign word_next  = (int'(bitcnt) < AUDIO_DW) ? {shreg[AUDIO_DW-2:0], d} : shreg;
    assign nbits      = sat_inc(bitcnt);
    assign word_out   = justify(word_next, nbits);
    assign boundary   = rise && (lr != lr_prev);
    assign short_word = int'(nbits) < MIN_BITS;
    // A rise in the same cycle always wins over the timeout.
    assign tmo_hit    = !rise && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Capture, commit and lock state machine with registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bitcnt        <= '0;
            lr_prev       <= CH_LEFT;
            hold_left     <= '0;
            have_left     <= 1'b0;
            tmo_cnt       <= '0;
            left_chan     <= '0;
            right_chan    <= '0;
            sample_strobe <= 1'b0;
            locked        <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            frame_err     <= 1'b0;

            if (rise || tmo_hit)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (rise) begin
                lr_prev <= lr;
                if (boundary) begin
                    shreg  <= '0;
                    bitcnt <= '0;
                    if (state == IDLE) begin
                        // First boundary only establishes word alignment.
                        state     <= SYNC;
                        have_left <= 1'b0;
                    end else if (short_word) begin
                        frame_err <= 1'b1;
                        locked    <= 1'b0;
                        have_left <= 1'b0;
                        state     <= IDLE;
                    end else if (lr_prev == CH_LEFT) begin
                        hold_left <= word_out;
                        have_left <= 1'b1;
                    end else if (state == LOCKED || have_left) begin
                        left_chan     <= hold_left;
                        right_chan    <= word_out;
                        sample_strobe <= 1'b1;
                        locked        <= 1'b1;
                        state         <= LOCKED;
                    end
                end else begin
                    shreg  <= word_next;
                    bitcnt <= nbits;
                end
            end else if (tmo_hit && state != IDLE) begin
                locked    <= 1'b0;
                frame_err <= 1'b1;
                have_left <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule
